gshare_predictor: RTL

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_pkg.sv | 22 ++
 rtl/gshare_predictor_pht.sv | 42 ++++
 rtl/gshare_predictor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/gshare_pkg.sv
// gshare_pkg: shared types and helpers for the gshare branch predictor.
// Holds the next-PC select encoding and counter init/max helpers.
package gshare_pkg;

  typedef enum logic [1:0] {
    SEL_IF_PC4  = 2'b00,
    SEL_EX_PC4  = 2'b01,
    SEL_BTB_TGT = 2'b10,
    SEL_EX_TGT  = 2'b11
  } pcnext_sel_e;

  // Weakly not-taken: 2^(w-1)-1
  function automatic logic [3:0] ctr_init(input int w);
    return 4'((1 << (w - 1)) - 1);
  endfunction

  // Saturation ceiling: 2^w-1
  function automatic logic [3:0] ctr_max(input int w);
    return 4'((1 << w) - 1);
  endfunction

endpackage

// File: rtl/gshare_predictor_pht.sv
// bp_pht_sat: array of saturating counters, combinational read-first.
// Ports: clk, rst, rd_idx/rd_ctr (read), upd_en/upd_idx/upd_taken (train).
module bp_pht_sat
  import gshare_pkg::*;
#(
  parameter int INDEX_WIDTH = 8,
  parameter int CTR_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output logic [CTR_WIDTH-1:0]   rd_ctr,
  input  logic                   upd_en,
  input  logic [INDEX_WIDTH-1:0] upd_idx,
  input  logic                   upd_taken
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] INIT =
    CTR_WIDTH'(ctr_init(CTR_WIDTH));
  localparam logic [CTR_WIDTH-1:0] MAX =
    CTR_WIDTH'(ctr_max(CTR_WIDTH));

  logic [CTR_WIDTH-1:0] ctr [DEPTH];
  logic [CTR_WIDTH-1:0] cur;

  assign rd_ctr = ctr[rd_idx];
  assign cur    = ctr[upd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        ctr[i] <= INIT;
    end else if (upd_en) begin
      if (upd_taken && cur != MAX)
        ctr[upd_idx] <= cur + CTR_WIDTH'(1);
      else if (!upd_taken && cur != '0)
        ctr[upd_idx] <= cur - CTR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare direction predictor + direct-mapped BTB.
// IF_* ports predict at fetch, EXMEM_* ports train/repair at commit;
// GSHARE_PERF_CNT_EN adds perf_br_cnt_o / perf_mispred_cnt_o.
module gshare_predictor
  import gshare_pkg::*;
#(
  parameter int PHT_INDEX_WIDTH = 8,
  parameter int BTB_INDEX_WIDTH = 6,
  parameter int GHR_WIDTH       = 8,
  parameter int CTR_WIDTH       = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          IF_pc_i,
  input  logic                 IF_valid_i,
  output logic                 IF_btb_hit_o,
  output logic                 IF_prediction_o,
  output logic [31:0]          IF_btb_target_o,
  output logic [GHR_WIDTH-1:0] IF_ghr_o,
  input  logic                 EXMEM_valid_i,
  input  logic [31:0]          EXMEM_pc_i,
  input  logic                 EXMEM_is_jmp_i,
  input  logic                 EXMEM_br_decision_i,
  input  logic                 EXMEM_prediction_i,
  input  logic [31:0]          EXMEM_pred_target_i,
  input  logic [31:0]          EXMEM_target_i,
  input  logic [GHR_WIDTH-1:0] EXMEM_ghr_i,
  output logic [1:0]           IF_PCnext_sel_o,
  output logic                 IF_flush_o
`ifdef GSHARE_PERF_CNT_EN
  ,
  output logic [31:0]          perf_br_cnt_o,
  output logic [31:0]          perf_mispred_cnt_o
`endif
);

  localparam int BTB_DEPTH = 1 << BTB_INDEX_WIDTH;
  localparam int TAG_W     = 32 - BTB_INDEX_WIDTH - 2;
  localparam int PI        = PHT_INDEX_WIDTH;
  localparam int BI        = BTB_INDEX_WIDTH;

  logic [GHR_WIDTH-1:0] ghr;
  logic [PI-1:0]        rd_idx;
  logic [PI-1:0]        upd_idx;
  logic [CTR_WIDTH-1:0] rd_ctr;
  logic                 upd_en;

  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
  logic [31:0]          btb_tgt [BTB_DEPTH];

  logic [BI-1:0]        if_bidx;
  logic [TAG_W-1:0]     if_tag;
  logic [BI-1:0]        ex_bidx;
  logic [TAG_W-1:0]     ex_tag;
  logic                 btb_wr;

  logic                 hit;
  logic                 pred;
  logic                 taken;
  logic                 mispred;
  pcnext_sel_e          sel;

  logic [GHR_WIDTH:0]   spec_cat;
  logic [GHR_WIDTH:0]   fix_cat;
  logic                 unused_bits;

  // Index hashing: PC word bits XOR zero-extended history
  assign rd_idx  = IF_pc_i[PI+1:2] ^ PI'(ghr);
  assign upd_idx = EXMEM_pc_i[PI+1:2] ^ PI'(EXMEM_ghr_i);
  assign upd_en  = EXMEM_valid_i && EXMEM_is_jmp_i;

  bp_pht_sat #(
    .INDEX_WIDTH (PI),
    .CTR_WIDTH   (CTR_WIDTH)
  ) u_pht (
    .clk       (clk_i),
    .rst       (rst_i),
    .rd_idx    (rd_idx),
    .rd_ctr    (rd_ctr),
    .upd_en    (upd_en),
    .upd_idx   (upd_idx),
    .upd_taken (EXMEM_br_decision_i)
  );

  assign if_bidx = IF_pc_i[BI+1:2];
  assign if_tag  = IF_pc_i[31:BI+2];
  assign ex_bidx = EXMEM_pc_i[BI+1:2];
  assign ex_tag  = EXMEM_pc_i[31:BI+2];
  assign btb_wr  = upd_en && EXMEM_br_decision_i;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      btb_valid <= '0;
    else if (btb_wr)
      btb_valid[ex_bidx] <= 1'b1;
  end

  // Tag/target need no reset: gated by btb_valid
  always_ff @(posedge clk_i) begin
    if (!rst_i && btb_wr) begin
      btb_tag[ex_bidx] <= ex_tag;
      btb_tgt[ex_bidx] <= EXMEM_target_i;
    end
  end

  assign hit  = !rst_i && btb_valid[if_bidx] &&
                btb_tag[if_bidx] == if_tag;
  assign pred = hit && rd_ctr[CTR_WIDTH-1];

  // A non-jump is treated as resolved not-taken
  assign taken   = EXMEM_is_jmp_i && EXMEM_br_decision_i;
  assign mispred = !rst_i && EXMEM_valid_i &&
                   (EXMEM_prediction_i != taken ||
                    (taken && EXMEM_prediction_i &&
                     EXMEM_pred_target_i != EXMEM_target_i));

  always_comb begin
    sel = SEL_IF_PC4;
    if (mispred)
      sel = taken ? SEL_EX_TGT : SEL_EX_PC4;
    else if (pred)
      sel = SEL_BTB_TGT;
  end

  // Concatenate then drop the MSB: works for GHR_WIDTH == 1
  assign spec_cat = {ghr, pred};
  assign fix_cat  = {EXMEM_ghr_i, taken};

  always_ff @(posedge clk_i) begin
    if (rst_i)
      ghr <= '0;
    else if (mispred)
      ghr <= fix_cat[GHR_WIDTH-1:0];
    else if (IF_valid_i && hit)
      ghr <= spec_cat[GHR_WIDTH-1:0];
  end

  assign IF_btb_hit_o    = hit;
  assign IF_prediction_o = pred;
  assign IF_btb_target_o = btb_tgt[if_bidx];
  assign IF_ghr_o        = ghr;
  assign IF_PCnext_sel_o = sel;
  assign IF_flush_o      = mispred;

`ifdef GSHARE_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_br_cnt_o      <= '0;
      perf_mispred_cnt_o <= '0;
    end else begin
      if (upd_en)
        perf_br_cnt_o <= perf_br_cnt_o + 32'd1;
      if (mispred)
        perf_mispred_cnt_o <= perf_mispred_cnt_o + 32'd1;
    end
  end
`endif

  assign unused_bits = ^{IF_pc_i[1:0], EXMEM_pc_i[1:0],
                         spec_cat[GHR_WIDTH],
                         fix_cat[GHR_WIDTH],
                         rd_ctr};

endmodule
